wb_async_register: RTL and testbench



---
 rtl/wb_async_register_if.sv | 32 +++
 rtl/wb_async_register.sv | 111 +++++++++++
 tb/tb_wb_async_register.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_async_register_if.sv
// wb_async_register_if: classic Wishbone bus bundle.
// The master modport drives the request and the slave modport returns the response.
`default_nettype none

interface wb_async_register_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        output adr, dat_w, we, sel, stb, cyc,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc,
        output dat_r, ack, err, rty
    );
endinterface

`default_nettype wire

// File: rtl/wb_async_register.sv
// wb_async_register: Wishbone register slice that registers the request and the response paths.
// Optional macro WB_ASYNC_REG_ERR_RTY_EN forwards err/rty; otherwise they are reported as ack.
`default_nettype none

module wb_async_register #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    wb_async_register_if.slave  wbm,
    wb_async_register_if.master wbs
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   req_adr;
    logic [DATA_WIDTH-1:0]   req_dat;
    logic                    req_we;
    logic [SELECT_WIDTH-1:0] req_sel;
    logic                    req_stb;
    logic                    req_cyc;
    logic [DATA_WIDTH-1:0]   rsp_dat;
    logic                    rsp_ack;
    logic                    rsp_err;
    logic                    rsp_rty;

    logic rsp_busy;
    logic slave_term;

    // A response still on the master bus means the master is holding the request it just finished.
    assign rsp_busy   = rsp_ack | rsp_err | rsp_rty;
    assign slave_term = wbs.ack | wbs.err | wbs.rty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            req_adr <= '0;
            req_dat <= '0;
            req_we  <= 1'b0;
            req_sel <= '0;
            req_stb <= 1'b0;
            req_cyc <= 1'b0;
            rsp_dat <= '0;
            rsp_ack <= 1'b0;
            rsp_err <= 1'b0;
            rsp_rty <= 1'b0;
        end else begin
            rsp_ack <= 1'b0;
            rsp_err <= 1'b0;
            rsp_rty <= 1'b0;
            case (state)
                IDLE: begin
                    if (wbm.cyc && wbm.stb && !rsp_busy) begin
                        req_adr <= wbm.adr;
                        req_dat <= wbm.dat_w;
                        req_we  <= wbm.we;
                        req_sel <= wbm.sel;
                        req_stb <= 1'b1;
                        req_cyc <= 1'b1;
                        state   <= BUSY;
                    end else if (!wbm.cyc) begin
                        req_cyc <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!wbm.cyc) begin
                        // Abort: any response arriving this cycle is dropped.
                        req_stb <= 1'b0;
                        req_cyc <= 1'b0;
                        state   <= IDLE;
                    end else if (slave_term) begin
                        req_stb <= 1'b0;
                        rsp_dat <= wbs.dat_r;
                        state   <= IDLE;
`ifdef WB_ASYNC_REG_ERR_RTY_EN
                        if (wbs.ack) begin
                            rsp_ack <= 1'b1;
                        end else if (wbs.err) begin
                            rsp_err <= 1'b1;
                        end else begin
                            rsp_rty <= 1'b1;
                        end
`else
                        rsp_ack <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wbs.adr   = req_adr;
    assign wbs.dat_w = req_dat;
    assign wbs.we    = req_we;
    assign wbs.sel   = req_sel;
    assign wbs.stb   = req_stb;
    assign wbs.cyc   = req_cyc;

    assign wbm.dat_r = rsp_dat;
    assign wbm.ack   = rsp_ack;
    assign wbm.err   = rsp_err;
    assign wbm.rty   = rsp_rty;
endmodule

`default_nettype wire

// File: tb/tb_wb_async_register.sv
// tb_wb_async_register: scoreboard bench for the Wishbone register slice.
`default_nettype none

module tb_wb_async_register;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
`ifdef WB_ASYNC_REG_ERR_RTY_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [2:0]  kind;   // {rty, err, ack}
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_async_register_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) m_if ();
    wb_async_register_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) s_if ();

    wb_async_register #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .wbm (m_if),
        .wbs (s_if)
    );

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    // Downstream slave: responds slv_lat cycles after its strobe rises (0 = combinational).
    bit          slv_en = 1'b0;
    int          slv_lat = 0;
    logic [2:0]  slv_kind = 3'b000;
    logic [31:0] slv_rdata = 32'h0;
    int          cnt = 0;

    always @(posedge clk) cnt <= s_if.stb ? cnt + 1 : 0;

    assign s_if.ack   = slv_en && s_if.stb && (cnt >= slv_lat) && slv_kind[0];
    assign s_if.err   = slv_en && s_if.stb && (cnt >= slv_lat) && slv_kind[1];
    assign s_if.rty   = slv_en && s_if.stb && (cnt >= slv_lat) && slv_kind[2];
    assign s_if.dat_r = slv_rdata;

    int   stb_starts = 0;
    int   resp_pulses = 0;
    int   multi_resp = 0;
    logic prev_stb = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (s_if.stb && !prev_stb) stb_starts++;
        prev_stb = s_if.stb;
        if (m_if.ack || m_if.err || m_if.rty) resp_pulses++;
        if ($countones({m_if.ack, m_if.err, m_if.rty}) > 1) multi_resp++;
    end

    task automatic issue(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input logic [3:0] sel, input bit en, input int lat,
                         input logic [2:0] kind, input logic [31:0] rdata,
                         input logic [2:0] ekind, input bit push);
        exp_t e;
        slv_en    = en;
        slv_lat   = lat;
        slv_kind  = kind;
        slv_rdata = rdata;
        m_if.adr   = adr;
        m_if.dat_w = dat;
        m_if.we    = we;
        m_if.sel   = sel;
        m_if.cyc   = 1'b1;
        m_if.stb   = 1'b1;
        if (push) begin
            e.kind = ekind;
            e.data = rdata;
            e.lat  = lat + 2;
            sb.push_back(e);
        end
    endtask

    task automatic wait_resp(input int start, output int lat, output logic [2:0] kind,
                             output logic [31:0] data);
        lat  = start;
        kind = 3'b000;
        data = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (m_if.ack || m_if.err || m_if.rty) begin
                kind = {m_if.rty, m_if.err, m_if.ack};
                data = m_if.dat_r;
                return;
            end
        end
        lat = -1;
    endtask

    task automatic release_bus(input bit keep_cyc);
        m_if.stb = 1'b0;
        if (!keep_cyc) m_if.cyc = 1'b0;
        slv_en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_if.adr, s_if.dat_w, s_if.we, s_if.sel, s_if.stb, s_if.cyc} !== '0) begin
            failures++;
            $display("FAIL reset_wbs got=%h exp=0", {s_if.adr, s_if.dat_w, s_if.we, s_if.sel, s_if.stb, s_if.cyc});
        end
        checks++;
        if ({m_if.dat_r, m_if.ack, m_if.err, m_if.rty} !== '0) begin
            failures++;
            $display("FAIL reset_wbm got=%h exp=0", {m_if.dat_r, m_if.ack, m_if.err, m_if.rty});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_if.stb !== 1'b0) begin
            failures++;
            $display("FAIL idle_stb got=%b exp=0", s_if.stb);
        end
    endtask

    task automatic test_write;
        int s0 = stb_starts;
        int r0 = resp_pulses;
        int lat;
        logic [2:0] kind;
        logic [31:0] data;
        exp_t e;
        issue(32'h10, 32'h11223344, 1'b1, 4'hF, 1'b1, 1, 3'b001, 32'hA5A50001, 3'b001, 1'b1);
        @(negedge clk);
        checks++;
        if ({s_if.adr, s_if.dat_w, s_if.we, s_if.sel} !== {32'h10, 32'h11223344, 1'b1, 4'hF}) begin
            failures++;
            $display("FAIL write_req got=%h/%h/%b/%h exp=10/11223344/1/f", s_if.adr, s_if.dat_w, s_if.we, s_if.sel);
        end
        checks++;
        if ({s_if.stb, s_if.cyc} !== 2'b11) begin
            failures++;
            $display("FAIL write_stbcyc got=%b exp=11", {s_if.stb, s_if.cyc});
        end
        wait_resp(1, lat, kind, data);
        e = sb.pop_front();
        checks++; if (kind !== e.kind) begin failures++; $display("FAIL write_kind got=%b exp=%b", kind, e.kind); end
        checks++; if (data !== e.data) begin failures++; $display("FAIL write_data got=%h exp=%h", data, e.data); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL write_lat got=%0d exp=%0d", lat, e.lat); end
        release_bus(1'b0);
        @(negedge clk);
        checks++;
        if (m_if.ack !== 1'b0) begin failures++; $display("FAIL write_ack_width got=%b exp=0", m_if.ack); end
        checks++;
        if ({s_if.adr, s_if.stb} !== {32'h10, 1'b0}) begin
            failures++;
            $display("FAIL write_hold got=%h/%b exp=10/0", s_if.adr, s_if.stb);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (resp_pulses - r0 != 1 || stb_starts - s0 != 1) begin
            failures++;
            $display("FAIL write_counts resp=%0d stb=%0d exp=1/1", resp_pulses - r0, stb_starts - s0);
        end
    endtask

    task automatic test_read;
        int lat;
        logic [2:0] kind;
        logic [31:0] data;
        exp_t e;
        issue(32'h20, 32'h0, 1'b0, 4'hF, 1'b1, 0, 3'b001, 32'hDEADBEEF, 3'b001, 1'b1);
        wait_resp(0, lat, kind, data);
        e = sb.pop_front();
        checks++; if (kind !== e.kind) begin failures++; $display("FAIL read_kind got=%b exp=%b", kind, e.kind); end
        checks++; if (data !== e.data) begin failures++; $display("FAIL read_data got=%h exp=%h", data, e.data); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL read_lat got=%0d exp=%0d", lat, e.lat); end
        release_bus(1'b0);
        @(negedge clk);
        checks++;
        if ({m_if.dat_r, m_if.ack} !== {32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("FAIL read_hold got=%h/%b exp=deadbeef/0", m_if.dat_r, m_if.ack);
        end
    endtask

    task automatic test_err_rty;
        logic [2:0] sk[3];
        logic [2:0] ek[3];
        int lat;
        logic [2:0] kind;
        logic [31:0] data;
        exp_t e;
        sk = '{3'b010, 3'b101, 3'b100};
        ek = '{FWD ? 3'b010 : 3'b001, 3'b001, FWD ? 3'b100 : 3'b001};
        for (int i = 0; i < 3; i++) begin
            issue(32'h30 + 32'(4 * i), 32'h0, 1'b0, 4'hF, 1'b1, 1, sk[i], 32'h0BAD0000 + 32'(i), ek[i], 1'b1);
            wait_resp(0, lat, kind, data);
            e = sb.pop_front();
            checks++; if (kind !== e.kind) begin failures++; $display("FAIL errrty%0d_kind got=%b exp=%b", i, kind, e.kind); end
            checks++; if (data !== e.data) begin failures++; $display("FAIL errrty%0d_data got=%h exp=%h", i, data, e.data); end
            checks++; if (lat != e.lat) begin failures++; $display("FAIL errrty%0d_lat got=%0d exp=%0d", i, lat, e.lat); end
            release_bus(1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int s0 = stb_starts;
        int r0 = resp_pulses;
        int lat;
        logic [2:0] kind;
        logic [31:0] data;
        exp_t e;
        issue(32'h40, 32'h55, 1'b1, 4'hF, 1'b1, 1, 3'b001, 32'h11110040, 3'b001, 1'b1);
        wait_resp(0, lat, kind, data);
        e = sb.pop_front();
        checks++; if (kind !== e.kind) begin failures++; $display("FAIL b2b_a_kind got=%b exp=%b", kind, e.kind); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL b2b_a_lat got=%0d exp=%0d", lat, e.lat); end
        // Master keeps stb/cyc through its ack cycle.
        @(negedge clk);
        checks++;
        if (s_if.stb !== 1'b0 || stb_starts - s0 != 1) begin
            failures++;
            $display("FAIL b2b_nodup stb=%b starts=%0d exp=0/1", s_if.stb, stb_starts - s0);
        end
        checks++;
        if (s_if.cyc !== 1'b1) begin failures++; $display("FAIL b2b_lock got=%b exp=1", s_if.cyc); end
        issue(32'h44, 32'h66, 1'b1, 4'hF, 1'b1, 0, 3'b001, 32'h22220044, 3'b001, 1'b1);
        wait_resp(0, lat, kind, data);
        e = sb.pop_front();
        checks++; if (kind !== e.kind) begin failures++; $display("FAIL b2b_b_kind got=%b exp=%b", kind, e.kind); end
        checks++; if (data !== e.data) begin failures++; $display("FAIL b2b_b_data got=%h exp=%h", data, e.data); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL b2b_b_lat got=%0d exp=%0d", lat, e.lat); end
        checks++;
        if ({s_if.adr, s_if.dat_w} !== {32'h44, 32'h66}) begin
            failures++;
            $display("FAIL b2b_b_req got=%h/%h exp=44/66", s_if.adr, s_if.dat_w);
        end
        release_bus(1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (stb_starts - s0 != 2 || resp_pulses - r0 != 2) begin
            failures++;
            $display("FAIL b2b_counts stb=%0d resp=%0d exp=2/2", stb_starts - s0, resp_pulses - r0);
        end
        checks++;
        if (s_if.cyc !== 1'b0) begin failures++; $display("FAIL b2b_cyc_clear got=%b exp=0", s_if.cyc); end
    endtask

    task automatic test_abort;
        int r0 = resp_pulses;
        // Slave never answers; master walks away.
        issue(32'h50, 32'h77, 1'b1, 4'hF, 1'b0, 0, 3'b001, 32'h0, 3'b001, 1'b0);
        @(negedge clk);
        checks++;
        if (s_if.stb !== 1'b1) begin failures++; $display("FAIL abort_busy got=%b exp=1", s_if.stb); end
        release_bus(1'b0);
        @(negedge clk);
        checks++;
        if ({s_if.stb, s_if.cyc} !== 2'b00) begin
            failures++;
            $display("FAIL abort_clear got=%b exp=00", {s_if.stb, s_if.cyc});
        end
        // Combinational ack lands in the same cycle cyc drops: it must be discarded.
        issue(32'h54, 32'h78, 1'b0, 4'hF, 1'b1, 0, 3'b001, 32'hCAFE0054, 3'b001, 1'b0);
        @(negedge clk);
        m_if.cyc = 1'b0;
        m_if.stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_if.stb, s_if.cyc} !== 2'b00) begin
            failures++;
            $display("FAIL abort2_clear got=%b exp=00", {s_if.stb, s_if.cyc});
        end
        slv_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (resp_pulses - r0 != 0) begin failures++; $display("FAIL abort_resp got=%0d exp=0", resp_pulses - r0); end
        checks++;
        if (m_if.dat_r !== 32'h22220044) begin failures++; $display("FAIL abort_dat got=%h exp=22220044", m_if.dat_r); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [2:0] kind;
        logic [31:0] data;
        exp_t e;
        issue(32'h60, 32'h88, 1'b1, 4'hF, 1'b0, 0, 3'b001, 32'h0, 3'b001, 1'b0);
        @(negedge clk);
        checks++;
        if (s_if.stb !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", s_if.stb); end
        rst = 1'b0;
        m_if.cyc = 1'b0;
        m_if.stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_if.adr, s_if.dat_w, s_if.we, s_if.sel, s_if.stb, s_if.cyc} !== '0) begin
            failures++;
            $display("FAIL rstmid_wbs got=%h exp=0", {s_if.adr, s_if.dat_w, s_if.we, s_if.sel, s_if.stb, s_if.cyc});
        end
        checks++;
        if ({m_if.dat_r, m_if.ack, m_if.err, m_if.rty} !== '0) begin
            failures++;
            $display("FAIL rstmid_wbm got=%h exp=0", {m_if.dat_r, m_if.ack, m_if.err, m_if.rty});
        end
        rst = 1'b1;
        @(negedge clk);
        issue(32'h64, 32'h99, 1'b0, 4'hF, 1'b1, 0, 3'b001, 32'h12345678, 3'b001, 1'b1);
        wait_resp(0, lat, kind, data);
        e = sb.pop_front();
        checks++; if (kind !== e.kind) begin failures++; $display("FAIL rstmid_kind got=%b exp=%b", kind, e.kind); end
        checks++; if (data !== e.data) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", data, e.data); end
        checks++; if (lat != e.lat) begin failures++; $display("FAIL rstmid_lat got=%0d exp=%0d", lat, e.lat); end
        release_bus(1'b0);
        @(negedge clk);
    endtask

    initial begin
        m_if.adr   = '0;
        m_if.dat_w = '0;
        m_if.we    = 1'b0;
        m_if.sel   = '0;
        m_if.stb   = 1'b0;
        m_if.cyc   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_err_rty();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        checks++;
        if (multi_resp != 0) begin failures++; $display("FAIL onehot_resp got=%0d exp=0", multi_resp); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
